// File: rtl/byte_mem_arbiter.sv
// Two-port arbiter sharing one byte-wide memory (active-low CS, RW high = read).
// One access per grant: IDLE -> ACCESS (memory cycle) -> ACK (handshake) -> IDLE.
module byte_mem_arbiter #(
    parameter int unsigned ADDRWIDTH = 3,
    parameter bit          RR        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDRWIDTH-1:0] addr0,
    input  logic [7:0]           wdata0,
    output logic                 ack0,
    output logic [7:0]           rdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDRWIDTH-1:0] addr1,
    input  logic [7:0]           wdata1,
    output logic                 ack1,
    output logic [7:0]           rdata1,
    output logic                 mem_cs,
    output logic                 mem_rw,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [7:0]           mem_din,
    input  logic [7:0]           mem_dout,
    output logic                 busy,
    output logic                 gnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   mem_cs_q, mem_cs_d;
    logic                   mem_rw_q, mem_rw_d;
    logic [ADDRWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]             mem_din_q, mem_din_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic [7:0]             rdata0_q, rdata0_d;
    logic [7:0]             rdata1_q, rdata1_d;
    logic                   busy_q, busy_d;
    logic                   gnt_q, gnt_d;
    logic                   last_q, last_d;
    logic                   win_c;

    // Port 1 wins when alone, or in round-robin contention when port 0 was served last.
    assign win_c = req1 & (~req0 | (RR & ~last_q));

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        mem_cs_d   = mem_cs_q;
        mem_rw_d   = mem_rw_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        busy_d     = busy_q;
        gnt_d      = gnt_q;
        last_d     = last_q;

        unique case (state_q)
            S_IDLE: begin
                mem_cs_d = 1'b1;
                mem_rw_d = 1'b1;
                busy_d   = 1'b0;
                if (req0 || req1) begin
                    state_d    = S_ACCESS;
                    gnt_d      = win_c;
                    last_d     = win_c;
                    busy_d     = 1'b1;
                    mem_cs_d   = 1'b0;
                    mem_rw_d   = win_c ? ~we1 : ~we0;
                    mem_addr_d = win_c ? addr1 : addr0;
                    mem_din_d  = win_c ? wdata1 : wdata0;
                end
            end
            S_ACCESS: begin
                // Read data was driven by the memory at the mid-cycle falling edge.
                if (mem_rw_q) begin
                    if (gnt_q) rdata1_d = mem_dout;
                    else       rdata0_d = mem_dout;
                end
                mem_cs_d = 1'b1;
                mem_rw_d = 1'b1;
                ack0_d   = ~gnt_q;
                ack1_d   = gnt_q;
                state_d  = S_ACK;
            end
            S_ACK: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                mem_cs_d = 1'b1;
                mem_rw_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_cs_q   <= 1'b1;
            mem_rw_q   <= 1'b1;
            mem_addr_q <= ADDRWIDTH'(0);
            mem_din_q  <= 8'h00;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= 8'h00;
            rdata1_q   <= 8'h00;
            busy_q     <= 1'b0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            mem_cs_q   <= mem_cs_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
        end
    end

    assign mem_cs   = mem_cs_q;
    assign mem_rw   = mem_rw_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = busy_q;
    assign gnt      = gnt_q;

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Bench for byte_mem_arbiter: a round-robin and a fixed-priority instance, each with its
// own byte memory, compared every cycle against a transaction-level model.
module tb_byte_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_mem = 1'b1;
    logic cmp_en = 1'b0;

    logic       req_s   [2][2];
    logic       we_s    [2][2];
    logic [2:0] addr_s  [2][2];
    logic [7:0] wdata_s [2][2];
    logic       ack_s   [2][2];
    logic [7:0] rdata_s [2][2];
    logic       cs_s    [2];
    logic       rw_s    [2];
    logic       busy_s  [2];
    logic       gnt_s   [2];
    logic [2:0] maddr_s [2];
    logic [7:0] din_s   [2];
    logic [7:0] dout_s  [2];

    logic [7:0] ram [2][8];

    int n_pass = 0;
    int n_total = 0;
    int cs_low_cnt [2];

    // Reference model state, per instance (0 = round-robin, 1 = fixed priority).
    int         m_phase [2];
    int         m_last  [2];
    int         m_gnt   [2];
    bit         m_cs    [2];
    bit         m_rw    [2];
    bit         m_busy  [2];
    bit         m_ack   [2][2];
    logic [2:0] m_addr  [2];
    logic [7:0] m_din   [2];
    logic [7:0] m_rd    [2][2];
    logic [7:0] m_mem   [2][8];

    always #5 clk = ~clk;

    byte_mem_arbiter #(.ADDRWIDTH(3), .RR(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req_s[0][0]), .we0(we_s[0][0]), .addr0(addr_s[0][0]), .wdata0(wdata_s[0][0]),
        .ack0(ack_s[0][0]), .rdata0(rdata_s[0][0]),
        .req1(req_s[0][1]), .we1(we_s[0][1]), .addr1(addr_s[0][1]), .wdata1(wdata_s[0][1]),
        .ack1(ack_s[0][1]), .rdata1(rdata_s[0][1]),
        .mem_cs(cs_s[0]), .mem_rw(rw_s[0]), .mem_addr(maddr_s[0]), .mem_din(din_s[0]),
        .mem_dout(dout_s[0]), .busy(busy_s[0]), .gnt(gnt_s[0])
    );

    byte_mem_arbiter #(.ADDRWIDTH(3), .RR(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req_s[1][0]), .we0(we_s[1][0]), .addr0(addr_s[1][0]), .wdata0(wdata_s[1][0]),
        .ack0(ack_s[1][0]), .rdata0(rdata_s[1][0]),
        .req1(req_s[1][1]), .we1(we_s[1][1]), .addr1(addr_s[1][1]), .wdata1(wdata_s[1][1]),
        .ack1(ack_s[1][1]), .rdata1(rdata_s[1][1]),
        .mem_cs(cs_s[1]), .mem_rw(rw_s[1]), .mem_addr(maddr_s[1]), .mem_din(din_s[1]),
        .mem_dout(dout_s[1]), .busy(busy_s[1]), .gnt(gnt_s[1])
    );

    // Byte memories: write on rising edge, read data on falling edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (clr_mem) begin
                for (int i = 0; i < 8; i++) ram[k][i] <= 8'h00;
            end else if (!cs_s[k] && !rw_s[k]) begin
                ram[k][maddr_s[k]] <= din_s[k];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            dout_s[k] <= (!cs_s[k] && rw_s[k]) ? ram[k][maddr_s[k]] : 8'h00;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Transaction-level model: a grant at one edge, memory effect and ack at the next,
    // handshake done at the one after.
    always @(posedge clk) begin
        int w;
        for (int k = 0; k < 2; k++) begin
            if (clr_mem)
                for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
            if (!rst_n) begin
                m_phase[k] = 0; m_last[k] = 1; m_gnt[k] = 0;
                m_cs[k] = 1'b1; m_rw[k] = 1'b1; m_busy[k] = 1'b0;
                m_ack[k][0] = 1'b0; m_ack[k][1] = 1'b0;
                m_rd[k][0] = 8'h00; m_rd[k][1] = 8'h00;
                m_addr[k] = 3'd0; m_din[k] = 8'h00;
            end else if (m_phase[k] == 0) begin
                if (req_s[k][0] || req_s[k][1]) begin
                    if (req_s[k][0] && req_s[k][1]) w = (k == 0) ? 1 - m_last[k] : 0;
                    else                            w = req_s[k][1] ? 1 : 0;
                    m_last[k] = w;
                    m_gnt[k]  = w;
                    m_cs[k]   = 1'b0;
                    m_rw[k]   = !we_s[k][w];
                    m_addr[k] = addr_s[k][w];
                    m_din[k]  = wdata_s[k][w];
                    m_busy[k] = 1'b1;
                    m_phase[k] = 1;
                end
            end else if (m_phase[k] == 1) begin
                if (m_rw[k]) m_rd[k][m_gnt[k]] = m_mem[k][m_addr[k]];
                else         m_mem[k][m_addr[k]] = m_din[k];
                m_cs[k] = 1'b1;
                m_rw[k] = 1'b1;
                m_ack[k][m_gnt[k]] = 1'b1;
                m_phase[k] = 2;
            end else begin
                m_ack[k][0] = 1'b0;
                m_ack[k][1] = 1'b0;
                m_busy[k] = 1'b0;
                m_phase[k] = 0;
            end
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                if (!cs_s[k]) cs_low_cnt[k]++;
                chk($sformatf("i%0d_mem_cs", k), int'(cs_s[k]), int'(m_cs[k]));
                chk($sformatf("i%0d_mem_rw", k), int'(rw_s[k]), int'(m_rw[k]));
                chk($sformatf("i%0d_busy", k), int'(busy_s[k]), int'(m_busy[k]));
                chk($sformatf("i%0d_ack0", k), int'(ack_s[k][0]), int'(m_ack[k][0]));
                chk($sformatf("i%0d_ack1", k), int'(ack_s[k][1]), int'(m_ack[k][1]));
                chk($sformatf("i%0d_rdata0", k), int'(rdata_s[k][0]), int'(m_rd[k][0]));
                chk($sformatf("i%0d_rdata1", k), int'(rdata_s[k][1]), int'(m_rd[k][1]));
                if (m_busy[k]) chk($sformatf("i%0d_gnt", k), int'(gnt_s[k]), m_gnt[k]);
                if (m_phase[k] == 1) begin
                    chk($sformatf("i%0d_mem_addr", k), int'(maddr_s[k]), int'(m_addr[k]));
                    if (!m_rw[k]) chk($sformatf("i%0d_mem_din", k), int'(din_s[k]), int'(m_din[k]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int k, input int p, input bit we, input logic [2:0] a,
                         input logic [7:0] d, output logic [7:0] rd, output int lat);
        int w = 0;
        while (busy_s[k] && w < 10) begin step(); w++; end
        req_s[k][p] = 1'b1; we_s[k][p] = we; addr_s[k][p] = a; wdata_s[k][p] = d;
        lat = 0;
        do begin step(); lat++; end while (!ack_s[k][p] && lat < 20);
        chk($sformatf("ack_seen_i%0d_p%0d", k, p), int'(ack_s[k][p]), 1);
        rd = rdata_s[k][p];
        req_s[k][p] = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        int lat, n0, cyc, nacks, w, seen1;
        int order [6];
        int tack [6];

        for (int k = 0; k < 2; k++) begin
            cs_low_cnt[k] = 0;
            for (int p = 0; p < 2; p++) begin
                req_s[k][p] = 1'b0; we_s[k][p] = 1'b0; addr_s[k][p] = 3'd0; wdata_s[k][p] = 8'h00;
            end
        end

        // Reset held three cycles with random requests.
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) req_s[k][p] = 1'($urandom % 2);
            step();
        end
        cmp_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_i%0d_cs", k), int'(cs_s[k]), 1);
            chk($sformatf("rst_i%0d_rw", k), int'(rw_s[k]), 1);
            chk($sformatf("rst_i%0d_acks", k), int'({ack_s[k][1], ack_s[k][0]}), 0);
            chk($sformatf("rst_i%0d_rdata0", k), int'(rdata_s[k][0]), 0);
            chk($sformatf("rst_i%0d_rdata1", k), int'(rdata_s[k][1]), 0);
            chk($sformatf("rst_i%0d_busy", k), int'(busy_s[k]), 0);
            for (int p = 0; p < 2; p++) req_s[k][p] = 1'b0;
        end
        clr_mem = 1'b0;
        rst_n = 1'b1;
        step();

        // Single write then read on port 0.
        n0 = cs_low_cnt[0];
        do_op(0, 0, 1'b1, 3'd3, 8'hA5, rd, lat);
        chk("wr_latency", lat, 2);
        chk("wr_cs_low_cycles", cs_low_cnt[0] - n0, 1);
        n0 = cs_low_cnt[0];
        do_op(0, 0, 1'b0, 3'd3, 8'h00, rd, lat);
        chk("rd_latency", lat, 2);
        chk("rd_data_a5", int'(rd), 8'hA5);
        chk("rd_cs_low_cycles", cs_low_cnt[0] - n0, 1);

        // Round-robin contention from a fresh reset.
        step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req_s[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 3'd3;
        req_s[0][1] = 1'b1; we_s[0][1] = 1'b1; addr_s[0][1] = 3'd6; wdata_s[0][1] = 8'h66;
        cyc = 0; nacks = 0;
        while (nacks < 6 && cyc < 40) begin
            step(); cyc++;
            for (int p = 0; p < 2; p++)
                if (ack_s[0][p] && nacks < 6) begin order[nacks] = p; tack[nacks] = cyc; nacks++; end
        end
        req_s[0][0] = 1'b0; req_s[0][1] = 1'b0;
        chk("rr_ack_count", nacks, 6);
        for (int i = 0; i < 6; i++) if (i < nacks) chk($sformatf("rr_order_%0d", i), order[i], i % 2);
        for (int i = 1; i < 6; i++) if (i < nacks) chk($sformatf("rr_spacing_%0d", i), tack[i] - tack[i-1], 3);

        // Fixed priority: port 1 starves while port 0 keeps requesting.
        req_s[1][0] = 1'b1; we_s[1][0] = 1'b1; addr_s[1][0] = 3'd1; wdata_s[1][0] = 8'h3C;
        req_s[1][1] = 1'b1; we_s[1][1] = 1'b0; addr_s[1][1] = 3'd1;
        cyc = 0; nacks = 0; seen1 = 0;
        while (nacks < 4 && cyc < 30) begin
            step(); cyc++;
            if (ack_s[1][1]) seen1++;
            if (ack_s[1][0]) nacks++;
        end
        req_s[1][0] = 1'b0;
        chk("fp_port0_acks", nacks, 4);
        chk("fp_port1_starved", seen1, 0);
        w = 0;
        while (!(busy_s[1] && gnt_s[1]) && w < 3) begin step(); w++; end
        chk("fp_port1_granted", int'(busy_s[1] && gnt_s[1]), 1);
        w = 0;
        while (!ack_s[1][1] && w < 10) begin step(); w++; end
        chk("fp_port1_ack", int'(ack_s[1][1]), 1);
        chk("fp_port1_rdata", int'(rdata_s[1][1]), 8'h3C);
        req_s[1][1] = 1'b0;

        // Fill through port 1, read back through port 0.
        for (int i = 0; i < 8; i++) do_op(0, 1, 1'b1, 3'(i), 8'(8'h10 + i), rd, lat);
        for (int i = 0; i < 8; i++) begin
            do_op(0, 0, 1'b0, 3'(i), 8'h00, rd, lat);
            chk($sformatf("fill_rd_%0d", i), int'(rd), 8'h10 + i);
        end

        // Reset on the edge that ends a read ACCESS.
        w = 0;
        while (busy_s[0] && w < 10) begin step(); w++; end
        req_s[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 3'd5;
        step();
        chk("abort_in_access", int'(cs_s[0]), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_no_ack", int'(ack_s[0][0]), 0);
        chk("abort_cs_high", int'(cs_s[0]), 1);
        chk("abort_rdata0", int'(rdata_s[0][0]), 0);
        w = 0;
        while (!ack_s[0][0] && w < 10) begin step(); w++; end
        chk("after_abort_ack", int'(ack_s[0][0]), 1);
        chk("after_abort_rdata0", int'(rdata_s[0][0]), 8'h15);
        req_s[0][0] = 1'b0;

        // Randomized traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    if (ack_s[k][p] || (!req_s[k][p] && ($urandom % 3) == 0)) begin
                        req_s[k][p]   = ack_s[k][p] ? 1'($urandom % 2) : 1'b1;
                        we_s[k][p]    = 1'($urandom);
                        addr_s[k][p]  = 3'($urandom);
                        wdata_s[k][p] = 8'($urandom);
                    end
                end
        end
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) req_s[k][p] = 1'b0;
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/byte_mem_arbiter.md
# byte_mem_arbiter

Two-requester controller that shares one 8-bit byte memory (CS active-low, RW high=read/low=write, write on rising edge, read data driven on falling edge) between two masters, e.g. CPU core and a DMA/loader. It accepts one request at a time through a req/ack handshake and arbitrates round-robin or by fixed priority. It sequences the memory's CS/RW/addr/din, captures read data, and returns it to the granted requester. It sits between the requesters and the memory instance; memory contents are never reset.

## Interface
Parameters:
- ADDRWIDTH, 3, memory address width; must match the memory instance.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (port 0 wins).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable (1 = write, 0 = read); stable while req0 high.
- addr0  in  ADDRWIDTH  port 0 address; stable while req0 high.
- wdata0  in  8  port 0 write data; stable while req0 high.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  8  port 0 read data; valid in the ack0 cycle, held until the next port 0 read completes.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_cs  out  1  to memory CS, low = selected.
- mem_rw  out  1  to memory RW, high = read, low = write.
- mem_addr  out  ADDRWIDTH  to memory addr.
- mem_din  out  8  to memory din.
- mem_dout  in  8  from memory dout; high-Z while deselected.
- busy  out  1  high in ACCESS and ACK states.
- gnt  out  1  index of the port in service; valid while busy.

## Operation
- FSM states: IDLE, ACCESS, ACK. All outputs are registered.
- IDLE: if no req, stay; mem_cs=1, mem_rw=1.
  - If req is present, pick the winner, load mem_addr/mem_din/mem_rw=~we from the winner, drive mem_cs=0, set gnt, go to ACCESS.
- Arbitration:
  - One request: it wins.
  - Both requests, RR=1: the winner is the port not served last. The pointer updates at grant.
  - Both requests, RR=0: port 0 wins.
- ACCESS (exactly one cycle):
  - The memory commits a write at the closing edge, or drives read data at the mid-cycle falling edge.
  - At the closing edge:
    - If the access is a read, latch mem_dout into rdata[gnt].
    - Drive mem_cs=1 and mem_rw=1.
    - Pulse ack[gnt]=1 and go to ACK.
- ACK (one cycle): ack is high. At the closing edge, ack drops and the FSM returns to IDLE. Requests are not sampled in ACK.
- Requesters drop req on the edge where they observe ack. If req is still high in IDLE, a new access starts.
- A write never changes rdata. The rdata of the non-granted port is never changed.
- mem_din holds the last loaded value when idle. Its value is don't-care for reads.

## Timing
- Request to ack: req seen high at edge E0 (IDLE) → ack high during E1–E2 → FSM back in IDLE at E2.
- The earliest next grant is sampled at E3, giving 3 cycles per access and a peak of one access per 3 clocks.
- mem_cs is low for exactly one cycle per access (E0–E1); never low in IDLE or ACK.
- Read data is captured at E1 from the memory's negedge output in the same cycle. There are no extra wait states.
- Reset values (any edge with rst_n=0): state=IDLE, mem_cs=1, mem_rw=1, mem_addr=0, mem_din=0, ack0=ack1=0, rdata0=rdata1=0, gnt=0, busy=0, RR pointer favours port 0.
- Reset mid-ACCESS aborts the cycle: mem_cs=1 after that edge and no ack is issued.
  - A write may or may not have committed, depending on whether the memory sampled it at that edge.
- Simultaneous requests, RR=1: grants strictly alternate while both are held high.
- A request arriving during ACCESS/ACK waits; it is never lost or pre-empted.

## Test plan
- Reset: hold rst_n=0 3 cycles with random reqs → mem_cs=1, mem_rw=1, acks 0, rdata0/1=0x00, busy=0.
- Single write/read: port 0 writes 0xA5 to addr 3 (ack0 2 cycles after req); then reads addr 3.
  - Required: rdata0=0xA5 during ack0; mem_cs low exactly 1 cycle each.
- Round-robin contention (RR=1): req0 and req1 held high for 6 accesses.
  - Required: grant order 0,1,0,1,0,1; ack spacing 3 cycles; each port's rdata is updated only on its own reads.
- Fixed priority (RR=0): both held high → port 0 is granted every time and port 1 starves.
  - After req0 drops, port 1 is granted within 3 cycles.
- Fill and check: port 1 writes 0x10+i to addr i for i=0..7, then port 0 reads all 8 → data 0x10..0x17.
  - Required: no mem_cs pulse outside ACCESS.
- Reset mid-ACCESS: assert rst_n=0 on the edge ending ACCESS of a read.
  - Required: no ack, rdata unchanged at 0; the next access after reset completes normally.
